fifo_flags: RTL and testbench

//   Synchronous single-clock FIFO with arbitrary (non power-of-2) depth and a

---
 rtl/fifo_flags.sv | 115 +++++++++++
 tb/tb_fifo_flags.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_flags.sv
// Single-clock FIFO of arbitrary depth with registered or first-word-fall-through
// read, occupancy level, almost-full/almost-empty thresholds and sticky error flags.
module fifo_flags #(
   parameter int DATA_W    = 10,
   parameter int DEPTH     = 6,
   parameter int FWFT      = 0,
   parameter int AF_THRESH = 5,
   parameter int AE_THRESH = 1,
   localparam int LVL_W    = $clog2(DEPTH + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              write,
   input  logic [DATA_W-1:0] datain,
   input  logic              read,
   input  logic              err_clr,
   output logic [DATA_W-1:0] dataout,
   output logic              rd_valid,
   output logic              val,
   output logic              full,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [LVL_W-1:0]  level,
   output logic              overflow,
   output logic              underflow
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              rd_acc;
   logic              wr_acc;

   // Depth need not be a power of two, so the wrap is an explicit compare.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign val          = (level != '0);
   assign full         = (level == LVL_W'(DEPTH));
   assign almost_full  = (level >= LVL_W'(AF_THRESH));
   assign almost_empty = (level <= LVL_W'(AE_THRESH));

   // A pop frees a slot in the same cycle, so a full FIFO still takes a write alongside a read.
   assign rd_acc = read && val;
   assign wr_acc = write && (!full || rd_acc);

   always_ff @(posedge clock) begin
      if (wr_acc && !flush)
         mem[wr_ptr] <= datain;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_acc)
            wr_ptr <= next_ptr(wr_ptr);
         if (rd_acc)
            rd_ptr <= next_ptr(rd_ptr);
         case ({wr_acc, rd_acc})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // New refusals win over err_clr; a flush never counts as a refusal.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= (write && !wr_acc && !flush) || (overflow && !err_clr);
         underflow <= (read && !rd_acc && !flush) || (underflow && !err_clr);
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign dataout  = val ? mem[rd_ptr] : '0;
         assign rd_valid = val;
      end else begin : g_registered
         logic [DATA_W-1:0] dout_q;
         logic              rd_valid_q;

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               dout_q     <= '0;
               rd_valid_q <= 1'b0;
            end else if (flush) begin
               rd_valid_q <= 1'b0;
            end else begin
               rd_valid_q <= rd_acc;
               if (rd_acc)
                  dout_q <= mem[rd_ptr];
            end
         end

         assign dataout  = dout_q;
         assign rd_valid = rd_valid_q;
      end
   endgenerate

endmodule

// File: tb/tb_fifo_flags.sv
// Bench for fifo_flags: a registered-read and an FWFT instance share one
// stimulus stream; a vector table plus hand sequences for wrap, flush and reset.
module tb_fifo_flags;

   logic       clock = 1'b0;
   logic       reset;
   logic       flush, write, read, err_clr;
   logic [9:0] datain;

   logic [9:0] r_dout, f_dout;
   logic       r_rv, r_val, r_full, r_af, r_ae, r_ovf, r_unf;
   logic       f_rv, f_val, f_full, f_af, f_ae, f_ovf, f_unf;
   logic [2:0] r_level, f_level;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clock = ~clock;

   fifo_flags #(.DATA_W(10), .DEPTH(6), .FWFT(0), .AF_THRESH(5), .AE_THRESH(1)) dut_reg (
      .clock(clock), .reset(reset), .flush(flush), .write(write), .datain(datain),
      .read(read), .err_clr(err_clr), .dataout(r_dout), .rd_valid(r_rv), .val(r_val),
      .full(r_full), .almost_full(r_af), .almost_empty(r_ae), .level(r_level),
      .overflow(r_ovf), .underflow(r_unf)
   );

   fifo_flags #(.DATA_W(10), .DEPTH(6), .FWFT(1), .AF_THRESH(5), .AE_THRESH(1)) dut_fwft (
      .clock(clock), .reset(reset), .flush(flush), .write(write), .datain(datain),
      .read(read), .err_clr(err_clr), .dataout(f_dout), .rd_valid(f_rv), .val(f_val),
      .full(f_full), .almost_full(f_af), .almost_empty(f_ae), .level(f_level),
      .overflow(f_ovf), .underflow(f_unf)
   );

   typedef struct {
      logic       flush, write, read, err_clr;
      logic [9:0] din;
      logic [9:0] exp_dout;
      logic       exp_rv;
      logic [2:0] exp_level;
      logic       exp_full, exp_af, exp_ae, exp_ovf, exp_unf;
      logic [9:0] exp_fw_dout;
   } vec_t;

   vec_t vecs[21];

   function automatic vec_t mk(input logic f, input logic w, input logic [9:0] d,
                               input logic r, input logic e, input logic [9:0] xd,
                               input logic xrv, input logic [2:0] xl, input logic xf,
                               input logic xaf, input logic xae, input logic xo,
                               input logic xu, input logic [9:0] xfd);
      vec_t v;
      v.flush = f; v.write = w; v.din = d; v.read = r; v.err_clr = e;
      v.exp_dout = xd; v.exp_rv = xrv; v.exp_level = xl; v.exp_full = xf;
      v.exp_af = xaf; v.exp_ae = xae; v.exp_ovf = xo; v.exp_unf = xu;
      v.exp_fw_dout = xfd;
      return v;
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive one cycle of inputs, let the edge pass, then return inputs to idle.
   task automatic apply_stimulus(input logic f, input logic w, input logic [9:0] d,
                                 input logic r, input logic e);
      flush = f; write = w; datain = d; read = r; err_clr = e;
      @(posedge clock);
      #1;
      flush = 1'b0; write = 1'b0; read = 1'b0; err_clr = 1'b0; datain = '0;
   endtask

   task automatic check_reset_state(input string tag);
      check_output({tag, " dataout"}, 32'(r_dout), 32'h0);
      check_output({tag, " rd_valid"}, 32'(r_rv), 32'h0);
      check_output({tag, " level"}, 32'(r_level), 32'h0);
      check_output({tag, " val"}, 32'(r_val), 32'h0);
      check_output({tag, " full"}, 32'(r_full), 32'h0);
      check_output({tag, " almost_full"}, 32'(r_af), 32'h0);
      check_output({tag, " almost_empty"}, 32'(r_ae), 32'h1);
      check_output({tag, " overflow"}, 32'(r_ovf), 32'h0);
      check_output({tag, " underflow"}, 32'(r_unf), 32'h0);
      check_output({tag, " fwft dataout"}, 32'(f_dout), 32'h0);
      check_output({tag, " fwft rd_valid"}, 32'(f_rv), 32'h0);
   endtask

   initial begin
      logic [9:0] model[$];
      logic [9:0] exp_word;

      // Fill 1..6, overflow, full read+write, drain, empty read+write, err_clr race.
      vecs[0]  = mk(0,1,10'h001,0,0, 10'h000,0,3'd1,0,0,1,0,0, 10'h001);
      vecs[1]  = mk(0,1,10'h002,0,0, 10'h000,0,3'd2,0,0,0,0,0, 10'h001);
      vecs[2]  = mk(0,1,10'h003,0,0, 10'h000,0,3'd3,0,0,0,0,0, 10'h001);
      vecs[3]  = mk(0,1,10'h004,0,0, 10'h000,0,3'd4,0,0,0,0,0, 10'h001);
      vecs[4]  = mk(0,1,10'h005,0,0, 10'h000,0,3'd5,0,1,0,0,0, 10'h001);
      vecs[5]  = mk(0,1,10'h006,0,0, 10'h000,0,3'd6,1,1,0,0,0, 10'h001);
      vecs[6]  = mk(0,1,10'h3FF,0,0, 10'h000,0,3'd6,1,1,0,1,0, 10'h001);
      vecs[7]  = mk(0,0,10'h000,0,1, 10'h000,0,3'd6,1,1,0,0,0, 10'h001);
      vecs[8]  = mk(0,1,10'h155,1,0, 10'h001,1,3'd6,1,1,0,0,0, 10'h002);
      vecs[9]  = mk(0,0,10'h000,1,0, 10'h002,1,3'd5,0,1,0,0,0, 10'h003);
      vecs[10] = mk(0,0,10'h000,1,0, 10'h003,1,3'd4,0,0,0,0,0, 10'h004);
      vecs[11] = mk(0,0,10'h000,1,0, 10'h004,1,3'd3,0,0,0,0,0, 10'h005);
      vecs[12] = mk(0,0,10'h000,1,0, 10'h005,1,3'd2,0,0,0,0,0, 10'h006);
      vecs[13] = mk(0,0,10'h000,1,0, 10'h006,1,3'd1,0,0,1,0,0, 10'h155);
      vecs[14] = mk(0,0,10'h000,1,0, 10'h155,1,3'd0,0,0,1,0,0, 10'h000);
      vecs[15] = mk(0,0,10'h000,0,0, 10'h155,0,3'd0,0,0,1,0,0, 10'h000);
      vecs[16] = mk(0,1,10'h0AA,1,0, 10'h155,0,3'd1,0,0,1,0,1, 10'h0AA);
      vecs[17] = mk(0,0,10'h000,0,1, 10'h155,0,3'd1,0,0,1,0,0, 10'h0AA);
      vecs[18] = mk(0,0,10'h000,1,0, 10'h0AA,1,3'd0,0,0,1,0,0, 10'h000);
      vecs[19] = mk(0,0,10'h000,1,1, 10'h0AA,0,3'd0,0,0,1,0,1, 10'h000);
      vecs[20] = mk(0,0,10'h000,0,1, 10'h0AA,0,3'd0,0,0,1,0,0, 10'h000);

      reset = 1'b1; flush = 1'b0; write = 1'b0; read = 1'b0; err_clr = 1'b0; datain = '0;
      repeat (2) @(posedge clock);
      #1;
      check_reset_state("reset");
      #3 reset = 1'b0;

      for (int i = 0; i < 21; i++) begin
         apply_stimulus(vecs[i].flush, vecs[i].write, vecs[i].din, vecs[i].read, vecs[i].err_clr);
         check_output($sformatf("v%0d dataout", i), 32'(r_dout), 32'(vecs[i].exp_dout));
         check_output($sformatf("v%0d rd_valid", i), 32'(r_rv), 32'(vecs[i].exp_rv));
         check_output($sformatf("v%0d level", i), 32'(r_level), 32'(vecs[i].exp_level));
         check_output($sformatf("v%0d val", i), 32'(r_val), 32'(vecs[i].exp_level != 0));
         check_output($sformatf("v%0d full", i), 32'(r_full), 32'(vecs[i].exp_full));
         check_output($sformatf("v%0d almost_full", i), 32'(r_af), 32'(vecs[i].exp_af));
         check_output($sformatf("v%0d almost_empty", i), 32'(r_ae), 32'(vecs[i].exp_ae));
         check_output($sformatf("v%0d overflow", i), 32'(r_ovf), 32'(vecs[i].exp_ovf));
         check_output($sformatf("v%0d underflow", i), 32'(r_unf), 32'(vecs[i].exp_unf));
         check_output($sformatf("v%0d fwft dataout", i), 32'(f_dout), 32'(vecs[i].exp_fw_dout));
         check_output($sformatf("v%0d fwft rd_valid", i), 32'(f_rv), 32'(vecs[i].exp_level != 0));
         check_output($sformatf("v%0d fwft level", i), 32'(f_level), 32'(vecs[i].exp_level));
      end

      // Wrap: hold level at 3 while both pointers lap the 6-entry store several times.
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(0, 1, 10'(10'h100 + i), 0, 0);
         model.push_back(10'(10'h100 + i));
      end
      for (int i = 0; i < 20; i++) begin
         check_output($sformatf("wrap%0d fwft head", i), 32'(f_dout), 32'(model[0]));
         apply_stimulus(0, 1, 10'(10'h200 + i), 1, 0);
         exp_word = model.pop_front();
         model.push_back(10'(10'h200 + i));
         check_output($sformatf("wrap%0d dataout", i), 32'(r_dout), 32'(exp_word));
         check_output($sformatf("wrap%0d rd_valid", i), 32'(r_rv), 32'h1);
         check_output($sformatf("wrap%0d level", i), 32'(r_level), 32'd3);
      end
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(0, 0, 10'h000, 1, 0);
         exp_word = model.pop_front();
         check_output($sformatf("drain%0d dataout", i), 32'(r_dout), 32'(exp_word));
      end
      check_output("drain level", 32'(r_level), 32'd0);

      // Flush beats a concurrent write and read, and clears a pending rd_valid.
      for (int i = 0; i < 5; i++)
         apply_stimulus(0, 1, 10'(10'h300 + i), 0, 0);
      apply_stimulus(0, 0, 10'h000, 1, 0);
      check_output("preflush level", 32'(r_level), 32'd4);
      check_output("preflush rd_valid", 32'(r_rv), 32'h1);
      apply_stimulus(1, 1, 10'h3AB, 1, 0);
      check_output("flush level", 32'(r_level), 32'd0);
      check_output("flush val", 32'(r_val), 32'h0);
      check_output("flush almost_empty", 32'(r_ae), 32'h1);
      check_output("flush overflow", 32'(r_ovf), 32'h0);
      check_output("flush underflow", 32'(r_unf), 32'h0);
      check_output("flush rd_valid", 32'(r_rv), 32'h0);
      check_output("flush fwft dataout", 32'(f_dout), 32'h0);
      apply_stimulus(0, 1, 10'h111, 0, 0);
      apply_stimulus(0, 0, 10'h000, 1, 0);
      check_output("postflush dataout", 32'(r_dout), 32'h111);

      // Asynchronous reset mid-burst takes effect without waiting for an edge.
      apply_stimulus(0, 1, 10'h222, 0, 0);
      apply_stimulus(0, 1, 10'h233, 0, 0);
      write = 1'b1; datain = 10'h244;
      #2 reset = 1'b1;
      #1;
      check_reset_state("async reset");
      write = 1'b0;
      @(posedge clock);
      #3 reset = 1'b0;
      #1;
      check_reset_state("after reset");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
